// File: rtl/ifu_redirect_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifu_redirect_ctrl_if : fetch-group, predecode and IQ signals      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface ifu_redirect_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_slot_valid;
  logic [1:0]  pd_isJ;
  logic [1:0]  pd_isBr;
  logic [1:0]  pd_jr;
  logic [63:0] pd_target;
  logic [1:0]  bpd_taken;
  logic [1:0]  jr_pred_valid;
  logic [63:0] jr_pred_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_slot_valid;
  logic [1:0]  out_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ds_pending;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_slot_valid, pd_isJ, pd_isBr, pd_jr,
           pd_target, bpd_taken, jr_pred_valid, jr_pred_target, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_slot_valid, out_pred_taken,
           redirect_valid, redirect_pc, ds_pending
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_slot_valid, pd_isJ, pd_isBr, pd_jr,
           pd_target, bpd_taken, jr_pred_valid, jr_pred_target, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_slot_valid, out_pred_taken,
           redirect_valid, redirect_pc, ds_pending
  );
endinterface
`default_nettype wire

// File: rtl/ifu_redirect_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifu_redirect_ctrl : delay-slot aware front-end redirect control   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ifu_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ifu_redirect_ctrl_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [63:0] r_out_inst;
  logic [1:0]  r_out_slot_valid;
  logic [1:0]  r_out_pred_taken;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;
  logic [31:0] r_target;

  logic        w_in_ready, w_take, w_load, w_redir_set;
  logic [1:0]  w_r, w_slot_valid, w_pred_taken;
  logic [31:0] w_t0, w_t1, w_redir_pc_nxt, w_target_nxt;

  // A pending redirect pulse forces ready so the stale group can be dropped.
  assign w_in_ready = !r_out_valid || bus.out_ready || r_redir_valid;
  assign w_take     = bus.in_valid && w_in_ready && !r_redir_valid && !bus.flush;

  assign w_r[0] = bus.in_slot_valid[0] &&
                  ((bus.pd_isJ[0] && !bus.pd_jr[0]) || (bus.pd_isBr[0] && bus.bpd_taken[0]) ||
                   (bus.pd_jr[0] && bus.jr_pred_valid[0]));
  assign w_r[1] = bus.in_slot_valid[1] &&
                  ((bus.pd_isJ[1] && !bus.pd_jr[1]) || (bus.pd_isBr[1] && bus.bpd_taken[1]) ||
                   (bus.pd_jr[1] && bus.jr_pred_valid[1]));
  assign w_t0 = bus.pd_jr[0] ? bus.jr_pred_target[31:0]  : bus.pd_target[31:0];
  assign w_t1 = bus.pd_jr[1] ? bus.jr_pred_target[63:32] : bus.pd_target[63:32];

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_slot_valid   = bus.in_slot_valid;
    w_pred_taken   = 2'b00;
    w_redir_set    = 1'b0;
    w_redir_pc_nxt = r_redir_pc;
    w_target_nxt   = r_target;
    if (w_take) begin
      case (r_state)
        IDLE: begin
          w_load = 1'b1;
          if (w_r[0]) begin
            w_pred_taken = 2'b01;
            if (bus.in_slot_valid[1]) begin
              w_redir_set    = 1'b1;
              w_redir_pc_nxt = w_t0;
            end else begin
              w_slot_valid = 2'b01;
              w_target_nxt = w_t0;
              w_state_nxt  = WAIT_DS;
            end
          end else if (w_r[1]) begin
            w_pred_taken = 2'b10;
            w_target_nxt = w_t1;
            w_state_nxt  = WAIT_DS;
          end
        end
        WAIT_DS: begin
          // The delay slot's own control-flow flags are deliberately ignored.
          if (bus.in_slot_valid != 2'b00) begin
            w_load         = 1'b1;
            w_slot_valid   = bus.in_slot_valid[0] ? 2'b01 : 2'b10;
            w_redir_set    = 1'b1;
            w_redir_pc_nxt = r_target;
            w_state_nxt    = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_out_valid      <= 1'b0;
      r_out_pc         <= RESET_PC;
      r_out_inst       <= 64'd0;
      r_out_slot_valid <= 2'b00;
      r_out_pred_taken <= 2'b00;
      r_redir_valid    <= 1'b0;
      r_redir_pc       <= 32'd0;
      r_target         <= 32'd0;
    end else if (bus.flush) begin
      r_state          <= IDLE;
      r_out_valid      <= 1'b0;
      r_out_slot_valid <= 2'b00;
      r_out_pred_taken <= 2'b00;
      r_redir_valid    <= 1'b0;
      r_target         <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_redir_valid <= w_redir_set;
      r_redir_pc    <= w_redir_pc_nxt;
      if (w_load) begin
        r_out_valid      <= 1'b1;
        r_out_pc         <= bus.in_pc;
        r_out_inst       <= bus.in_inst;
        r_out_slot_valid <= w_slot_valid;
        r_out_pred_taken <= w_pred_taken;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_pc         = r_out_pc;
  assign bus.out_inst       = r_out_inst;
  assign bus.out_slot_valid = r_out_slot_valid;
  assign bus.out_pred_taken = r_out_pred_taken;
  // A flush in the pulse cycle suppresses the already-scheduled redirect.
  assign bus.redirect_valid = r_redir_valid && !bus.flush;
  assign bus.redirect_pc    = r_redir_pc;
  assign bus.ds_pending     = (r_state == WAIT_DS);
endmodule
`default_nettype wire
